// File: rtl/byte_reg_write_arbiter_pkg.sv
// Shared definitions for the byte register write arbiter and its helpers.
//   ST_IDLE / ST_WRITE : FSM state encodings (one-bit, legacy compatible)
//   BYTE_W / REG_AW    : default data width and per-requester address width
//   ptr_width()        : width of a requester index for N requesters (min 1)
package byte_reg_write_arbiter_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_WRITE = 1'b1;

    localparam int BYTE_W = 8;
    localparam int REG_AW = 3;

    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at index ptr and wrapping modulo N; the first set bit
// wins.
//   req  [N]  : request vector
//   ptr  [PW] : index with highest priority this round (must be < N)
//   pick [N]  : one-hot winner (zero when no request)
//   idx  [PW] : index of the winner (zero when no request)
//   any       : at least one request present
module rr_pick
    import byte_reg_write_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] idx,
    output logic          any
);

    // cand_idx[k] is the requester examined at search position k,
    // i.e. (ptr + k) mod N. ptr < N, so one conditional subtract suffices.
    logic [PW-1:0] cand_idx [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [PW:0] sum;
            assign sum          = {1'b0, ptr} + (PW+1)'(gi);
            assign cand_idx[gi] = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N))
                                                      : PW'(sum);
        end
    endgenerate

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[cand_idx[k]]) begin
                any = 1'b1;
                idx = cand_idx[k];
            end
        end
        if (any) begin
            pick[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/byte_reg_write_arbiter.sv
// Round-robin write arbiter in front of a bank of byte registers.
// One request is accepted per IDLE cycle; the following cycle (WRITE) carries
// a one-cycle gnt to the winner and a one-hot wrt strobe plus wdata to the
// bank. Out-of-range addresses are acknowledged but raise err instead of wrt.
//   clk, rst  : clock and synchronous active-high reset
//   req       [NREQ]     : per-requester request, held until gnt seen
//   req_addr  [NREQ*AW]  : requester i address in [i*AW +: AW]
//   req_data  [NREQ*DW]  : requester i data in [i*DW +: DW]
//   gnt       [NREQ]     : one-cycle one-hot acknowledge
//   wrt       [NREG]     : one-cycle one-hot bank write enable
//   wdata     [DW]       : bank write data, held after the write
//   err                  : one-cycle pulse for out-of-range address
//   busy                 : high during the WRITE cycle
module byte_reg_write_arbiter
    import byte_reg_write_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int NREG = 8,
    parameter int AW   = REG_AW,
    parameter int DW   = BYTE_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREG-1:0]      wrt,
    output logic [DW-1:0]        wdata,
    output logic                 err,
    output logic                 busy
);

    localparam int PW = ptr_width(NREQ);

    logic            state_reg,  state_next;
    logic [PW-1:0]   ptr_reg,    ptr_next;
    logic [PW-1:0]   widx_reg,   widx_next;
    logic [NREQ-1:0] gnt_reg,    gnt_next;
    logic [NREG-1:0] wrt_reg,    wrt_next;
    logic [DW-1:0]   wdata_reg,  wdata_next;
    logic            err_reg,    err_next;
    logic            busy_reg,   busy_next;

    logic [NREQ-1:0] pick;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;

    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic [NREG-1:0] wrt_dec;
    logic            addr_oob;

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req  (req),
        .ptr  (ptr_reg),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    assign sel_addr = req_addr[pick_idx*AW +: AW];
    assign sel_data = req_data[pick_idx*DW +: DW];

    // Address decode; an out-of-range address leaves every strobe low.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_dec
            assign wrt_dec[gi] = (sel_addr == AW'(gi));
        end
    endgenerate

    assign addr_oob = (32'(sel_addr) >= NREG);

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        widx_next  = widx_reg;
        gnt_next   = '0;
        wrt_next   = '0;
        wdata_next = wdata_reg;
        err_next   = 1'b0;
        busy_next  = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (pick_any) begin
                state_next = ST_WRITE;
                widx_next  = pick_idx;
                gnt_next   = pick;
                wrt_next   = wrt_dec;
                wdata_next = sel_data;
                err_next   = addr_oob;
                busy_next  = 1'b1;
            end
        end else begin
            // WRITE lasts exactly one cycle; the priority moves past the winner.
            state_next = ST_IDLE;
            ptr_next   = (widx_reg == PW'(NREQ-1)) ? '0 : widx_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            widx_reg  <= '0;
            gnt_reg   <= '0;
            wrt_reg   <= '0;
            wdata_reg <= '0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            widx_reg  <= widx_next;
            gnt_reg   <= gnt_next;
            wrt_reg   <= wrt_next;
            wdata_reg <= wdata_next;
            err_reg   <= err_next;
            busy_reg  <= busy_next;
        end
    end

    assign gnt   = gnt_reg;
    assign wrt   = wrt_reg;
    assign wdata = wdata_reg;
    assign err   = err_reg;
    assign busy  = busy_reg;

endmodule
